load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter SIZE, default 256, memory depth in words; LOGSIZE = $clog2(SIZE).
REQ-003 SHALL have one clock and an asynchronous active-low reset: ports clk and rst_n, listed first.
REQ-004 SHALL have ports:
  - clk  in  1  clock.
  - rst_n  in  1  async active-low reset.
  - req_valid  in  1  request present.
  - req_ready  out  1  request accepted when high with req_valid.
  - req_we  in  1  1 = store, 0 = load.
  - req_funct3  in  3  RV32I load/store funct3.
  - req_addr  in  32  byte address.
  - req_wdata  in  WIDTH  store data.
  - req_rd  in  5  destination tag.
  - mem_addr  out  LOGSIZE  word index.
  - mem_wdata  out  WIDTH  lane-aligned store data.
  - mem_be  out  4  byte enables.
  - mem_we  out  1  write strobe.
  - mem_rdata  in  WIDTH  combinational read of mem_addr.
  - rsp_valid  out  1  response present.
  - rsp_ready  in  1  response consumed.
  - rsp_data  out  WIDTH  extended load data; 0 for stores.
  - rsp_rd  out  5  echoed tag.
  - rsp_misaligned  out  1  access-fault flag.

Function
REQ-005 SHALL implement FSM IDLE -> ACC0 -> (ACC1) -> RESP -> IDLE.
REQ-006 SHALL assert req_ready only in IDLE; the handshake at cycle T latches addr, funct3, we, wdata and rd, and the FSM enters ACC0 at T+1.
REQ-007 SHALL, in ACC0, drive mem_addr = addr[LOGSIZE+1:2]; addr bits above LOGSIZE+1 are ignored.
REQ-008 SHALL set store byte enables as follows: SB be = 1<<off; SH be = 3<<off; SW be = 4'hF; off = addr[1:0]; mem_wdata is shifted left by 8*off.
REQ-009 SHALL pulse mem_we for exactly one cycle per ACC state of a legal store, and never in IDLE or RESP.
REQ-010 SHALL extract a load's bytes from mem_rdata at off: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-011 SHALL, for a non-crossing access, enter RESP at T+2 with rsp_valid=1; rsp_data, rsp_rd and rsp_misaligned hold stable until rsp_ready.
REQ-012 SHALL complete RESP when rsp_ready=1, returning to IDLE next cycle, so back-to-back throughput is one request per 3 cycles.
REQ-013 SHALL define a crossing access as off + size > 4 (size 1/2/4 bytes).
REQ-014 SHALL, for illegal funct3 (load 3/6/7; store >= 3), issue no write and respond with rsp_data=0, rsp_misaligned=0, at aligned latency.
REQ-015 SHALL give stores a response with rsp_data=0.

Reset
REQ-016 SHALL, on rst_n low, immediately force state=IDLE, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_misaligned=0, mem_we=0, mem_be=0; req_ready=1 after release.
REQ-017 SHALL abandon an in-flight split store on reset mid-operation; a first-half write already committed stays committed.

Configuration
REQ-018 SHALL, with LSU_MISALIGNED_SPLIT_EN defined, execute crossing accesses in ACC0 (low word, low bytes) then ACC1 (word index+1, modulo SIZE, remaining bytes), with RESP at T+3; loads merge both halves before extension.
REQ-019 SHALL, with LSU_MISALIGNED_SPLIT_EN defined, execute non-crossing misaligned accesses (e.g. LH at off 1) in a single access.
REQ-020 SHALL, without LSU_MISALIGNED_SPLIT_EN, fault any access not naturally aligned (half with addr[0]=1; word with off!=0): no write, rsp_misaligned=1, rsp_data=0, RESP at T+2; ACC1 is unreachable.

Structure
REQ-021 SHALL place the FSM state enum, access-size decode function and funct3 load/store constants in shared package lsu_pkg.
REQ-022 SHALL factor the lane shift/merge/extend into combinational sub-module lsu_align.

Verification
REQ-023 SB addr 0x05 wdata 0xAB -> mem_addr 1, be 4'b0010, mem_wdata 0x0000AB00, one mem_we pulse; rsp_valid at T+2.
REQ-024 Memory word 1 = 0x80FF0000, LH addr 0x06 -> rsp_data 0xFFFF80FF; LHU addr 0x06 -> 0x000080FF.
REQ-025 LW addr 0x0E, word3=0x44332211, word4=0x88776655: with macro -> rsp_data 0x66554433 at T+3; without macro -> rsp_misaligned=1, rsp_data 0, no writes.
REQ-026 SW addr 4*SIZE-2 with macro -> be 4'b1100 at word SIZE-1, then be 4'b0011 at word 0.
REQ-027 Hold rsp_ready=0 for 5 cycles -> response stable, req_ready=0; rst_n pulsed during ACC0 -> rsp_valid=0, mem_we=0 immediately, IDLE after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I funct3 codes,
// access-size and legality decode helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Size in bytes; 0 marks the encoding that has no defined width.
    function automatic logic [2:0] accessSize(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    accessSize = 3'd1;
            2'd1:    accessSize = 3'd2;
            2'd2:    accessSize = 3'd4;
            default: accessSize = 3'd0;
        endcase
    endfunction

    function automatic logic funct3Legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            funct3Legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            funct3Legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                          (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: shifts store data and byte enables across a word pair,
// and merges/extends load bytes from a low and high word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       off_i,
    input  logic [2:0]       size_i,
    input  logic             unsigned_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] loRdata_i,
    input  logic [WIDTH-1:0] hiRdata_i,
    output logic [WIDTH-1:0] wdataLo_o,
    output logic [WIDTH-1:0] wdataHi_o,
    output logic [3:0]       beLo_o,
    output logic [3:0]       beHi_o,
    output logic [WIDTH-1:0] ldata_o
);

    logic [4:0]         shamt;
    logic [3:0]         beMask;
    logic [7:0]         beWide;
    logic [2*WIDTH-1:0] wideStore;
    logic [WIDTH-1:0]   loadWord;

    assign shamt = {off_i, 3'b000};

    always_comb begin
        case (size_i)
            3'd1:    beMask = 4'b0001;
            3'd2:    beMask = 4'b0011;
            default: beMask = 4'b1111;
        endcase
    end

    // Stores are viewed as a two-word window so bytes past the word end spill into the high half.
    assign wideStore = {{WIDTH{1'b0}}, wdata_i} << shamt;
    assign beWide    = {4'b0000, beMask} << off_i;
    assign wdataLo_o = wideStore[WIDTH-1:0];
    assign wdataHi_o = wideStore[2*WIDTH-1:WIDTH];
    assign beLo_o    = beWide[3:0];
    assign beHi_o    = beWide[7:4];

    assign loadWord = (off_i == 2'd0) ? loRdata_i
                    : ((loRdata_i >> shamt) | (hiRdata_i << (WIDTH - int'(shamt))));

    always_comb begin
        case (size_i)
            3'd1:    ldata_o = {{(WIDTH-8){loadWord[7] & ~unsigned_i}}, loadWord[7:0]};
            3'd2:    ldata_o = {{(WIDTH-16){loadWord[15] & ~unsigned_i}}, loadWord[15:0]};
            default: ldata_o = loadWord;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-addressed memory with a valid/ready request
// and response. Define LSU_MISALIGNED_SPLIT_EN to split crossing accesses in two.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int SIZE    = 256,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [4:0]         req_rd,
    output logic [LOGSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [3:0]         mem_be,
    output logic               mem_we,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [4:0]         rsp_rd,
    output logic               rsp_misaligned
);

    lsu_state_e state_q, state_d;

    logic [LOGSIZE+1:0] addr_q;
    logic [2:0]         funct3_q;
    logic               we_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [4:0]         rd_q;
    logic [WIDTH-1:0]   loData_q;
    logic [WIDTH-1:0]   rspData_q, rspData_d;
    logic [4:0]         rspRd_q, rspRd_d;
    logic               rspMis_q, rspMis_d;

    logic [1:0]         off;
    logic [2:0]         size;
    logic               legal;
    logic               doAccess;
    logic               splitAccess;
    logic [LOGSIZE-1:0] wordIdx, nextIdx;
    logic               inAcc;
    logic [WIDTH-1:0]   wdataLo, wdataHi, loadData, loWord;
    logic [3:0]         beLo, beHi;

    assign off     = addr_q[1:0];
    assign size    = accessSize(funct3_q);
    assign legal   = funct3Legal(we_q, funct3_q);
    assign wordIdx = addr_q[LOGSIZE+1:2];
    assign nextIdx = (wordIdx == LOGSIZE'(SIZE - 1)) ? '0 : wordIdx + 1'b1;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic crossing;
    assign crossing    = ({2'b00, off} + {1'b0, size}) > 4'd4;
    assign doAccess    = legal;
    assign splitAccess = legal & crossing;
`else
    // Without splitting, anything off its natural boundary faults.
    logic aligned;
    assign aligned     = !(((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'd0)));
    assign doAccess    = legal & aligned;
    assign splitAccess = 1'b0;
`endif

    // In ACC1 the low word was captured during ACC0; mem_rdata now holds the high word.
    assign loWord = (state_q == ACC1) ? loData_q : mem_rdata;

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .off_i      (off),
        .size_i     (size),
        .unsigned_i (funct3_q[2]),
        .wdata_i    (wdata_q),
        .loRdata_i  (loWord),
        .hiRdata_i  (mem_rdata),
        .wdataLo_o  (wdataLo),
        .wdataHi_o  (wdataHi),
        .beLo_o     (beLo),
        .beHi_o     (beHi),
        .ldata_o    (loadData)
    );

    assign inAcc          = (state_q == ACC0) || (state_q == ACC1);
    assign req_ready      = (state_q == IDLE);
    assign rsp_valid      = (state_q == RESP);
    assign mem_addr       = (state_q == ACC1) ? nextIdx : wordIdx;
    assign mem_wdata      = (state_q == ACC1) ? wdataHi : wdataLo;
    assign mem_we         = inAcc & we_q & doAccess;
    assign mem_be         = mem_we ? ((state_q == ACC1) ? beHi : beLo) : 4'b0000;
    assign rsp_data       = rspData_q;
    assign rsp_rd         = rspRd_q;
    assign rsp_misaligned = rspMis_q;

    always_comb begin
        state_d   = state_q;
        rspData_d = rspData_q;
        rspRd_d   = rspRd_q;
        rspMis_d  = rspMis_q;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = ACC0;
            end
            ACC0: begin
                rspRd_d   = rd_q;
                rspMis_d  = 1'b0;
                rspData_d = '0;
                if (splitAccess) begin
                    state_d = ACC1;
                end else begin
                    state_d = RESP;
                    if (legal && !doAccess) rspMis_d = 1'b1;
                    else if (doAccess && !we_q) rspData_d = loadData;
                end
            end
            ACC1: begin
                state_d   = RESP;
                rspData_d = we_q ? '0 : loadData;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rspData_q <= '0;
            rspRd_q   <= '0;
            rspMis_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rspData_q <= rspData_d;
            rspRd_q   <= rspRd_d;
            rspMis_q  <= rspMis_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rd_q     <= '0;
            loData_q <= '0;
        end else begin
            if ((state_q == IDLE) && req_valid) begin
                addr_q   <= req_addr[LOGSIZE+1:0];
                funct3_q <= req_funct3;
                we_q     <= req_we;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
            end
            if (state_q == ACC0) loData_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors, hand sequences and
// randomized traffic against a byte-addressed reference memory.
module tb_load_store_unit;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 256;
    localparam int LOGSIZE = $clog2(SIZE);
    localparam int BYTES   = 4 * SIZE;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [2:0]         req_funct3;
    logic [31:0]        req_addr;
    logic [WIDTH-1:0]   req_wdata;
    logic [4:0]         req_rd;
    logic [LOGSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [3:0]         mem_be;
    logic               mem_we;
    logic [WIDTH-1:0]   mem_rdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic [4:0]         rsp_rd;
    logic               rsp_misaligned;

    int testsRun    = 0;
    int testsFailed = 0;

    load_store_unit #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_rd         (rsp_rd),
        .rsp_misaligned (rsp_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the DUT, with a backdoor port for preloading and a log of writes.
    logic [31:0]        mem [SIZE];
    logic               bdWe = 1'b0;
    logic [LOGSIZE-1:0] bdAddr = '0;
    logic [31:0]        bdData = '0;
    int                 wrCount = 0;
    logic [LOGSIZE-1:0] wrAddrLog [64];
    logic [3:0]         wrBeLog [64];
    logic [31:0]        wrDataLog [64];

    always @(posedge clk) begin
        if (bdWe) begin
            mem[bdAddr] <= bdData;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            wrAddrLog[wrCount % 64] <= mem_addr;
            wrBeLog[wrCount % 64]   <= mem_be;
            wrDataLog[wrCount % 64] <= mem_wdata;
            wrCount <= wrCount + 1;
        end
    end

    assign mem_rdata = mem[mem_addr];

    logic [7:0] refMem [BYTES];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] expData;
        logic        expMis;
        int          expLat;
        int          expWrites;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] value);
        @(negedge clk);
        bdWe   = 1'b1;
        bdAddr = LOGSIZE'(idx);
        bdData = value;
        @(posedge clk);
        #1;
        bdWe = 1'b0;
        for (int b = 0; b < 4; b++) refMem[4*idx + b] = value[8*b +: 8];
    endtask

    // Byte-level model of the architectural effect of one request.
    task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] expData,
                               output logic expMis, output int expLat, output int expWrites);
        int size, base, off;
        logic legal, aligned;
        logic [31:0] val;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        legal   = we ? (f3 < 3'd3) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        base    = int'(addr % BYTES);
        off     = base % 4;
        aligned = (size != 0) && ((base % size) == 0);
        expData = '0; expMis = 1'b0; expLat = 2; expWrites = 0;
        if (!legal) return;
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (off + size > 4) expLat = 3;
`else
        if (!aligned) begin
            expMis = 1'b1;
            return;
        end
`endif
        if (we) begin
            for (int i = 0; i < size; i++) refMem[(base + i) % BYTES] = wdata[8*i +: 8];
            expWrites = (off + size > 4) ? 2 : 1;
        end else begin
            val = '0;
            for (int i = 0; i < size; i++) val[8*i +: 8] = refMem[(base + i) % BYTES];
            if (!f3[2] && size < 4 && val[8*size-1])
                for (int b = 8*size; b < 32; b++) val[b] = 1'b1;
            expData = val;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd, input int hold,
                                 output logic [31:0] obsData, output logic obsMis, output logic [4:0] obsRd,
                                 output int obsLat, output int obsWrites, output int startWr);
        int cycles;
        logic stable;
        @(negedge clk);
        checkOutput("reqReadyIdle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        rsp_ready = 1'b0;
        startWr = wrCount;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        cycles = 0;
        while (cycles < 8) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid) break;
        end
        checkOutput("rspArrives", {31'b0, rsp_valid}, 32'd1);
        obsLat = cycles; obsData = rsp_data; obsMis = rsp_misaligned; obsRd = rsp_rd;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== obsData || rsp_rd !== obsRd ||
                rsp_misaligned !== obsMis || req_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) checkOutput("holdStable", {31'b0, stable}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        obsWrites = wrCount - startWr;
    endtask

    task automatic runChecked(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, input int hold,
                              input logic [31:0] expData, input logic expMis, input int expLat,
                              input int expWrites, output int startWr);
        logic [31:0] d; logic m; logic [4:0] r; int lat, wr;
        applyStimulus(we, f3, addr, wdata, rd, hold, d, m, r, lat, wr, startWr);
        checkOutput({tag, ".data"}, d, expData);
        checkOutput({tag, ".mis"}, {31'b0, m}, {31'b0, expMis});
        checkOutput({tag, ".rd"}, {27'b0, r}, {27'b0, rd});
        checkOutput({tag, ".lat"}, lat, expLat);
        checkOutput({tag, ".writes"}, wr, expWrites);
    endtask

    initial begin
        logic [31:0] md; logic mm; int ml, mw, sw, bad;
        logic we; logic [2:0] f3; logic [31:0] addr, wdata; logic [4:0] rd;

        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; req_rd = '0; rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("resetRspValid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("resetMemWe", {31'b0, mem_we}, 32'd0);
        checkOutput("resetMemBe", {28'b0, mem_be}, 32'd0);
        checkOutput("resetRspData", rsp_data, 32'd0);
        checkOutput("resetRspRd", {27'b0, rsp_rd}, 32'd0);
        checkOutput("resetRspMis", {31'b0, rsp_misaligned}, 32'd0);

        for (int w = 0; w < SIZE; w++) preload(w, $urandom);
        preload(1, 32'h80FF0000);
        preload(3, 32'h44332211);
        preload(4, 32'h88776655);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterRelease", {31'b0, req_ready}, 32'd1);

        vecs[0]  = '{1'b1, 3'd0, 32'h05, 32'hAB,   5'd3,  32'h0,        1'b0, 2, 1};
        vecs[1]  = '{1'b0, 3'd1, 32'h06, 32'h0,    5'd4,  32'hFFFF80FF, 1'b0, 2, 0};
        vecs[2]  = '{1'b0, 3'd5, 32'h06, 32'h0,    5'd5,  32'h000080FF, 1'b0, 2, 0};
        vecs[3]  = '{1'b0, 3'd0, 32'h07, 32'h0,    5'd6,  32'hFFFFFF80, 1'b0, 2, 0};
        vecs[4]  = '{1'b0, 3'd4, 32'h05, 32'h0,    5'd7,  32'h000000AB, 1'b0, 2, 0};
        vecs[5]  = '{1'b0, 3'd2, 32'h0C, 32'h0,    5'd8,  32'h44332211, 1'b0, 2, 0};
`ifdef LSU_MISALIGNED_SPLIT_EN
        vecs[6]  = '{1'b0, 3'd2, 32'h0E, 32'h0,    5'd9,  32'h66554433, 1'b0, 3, 0};
        vecs[9]  = '{1'b1, 3'd1, 32'h11, 32'h1234, 5'd12, 32'h0,        1'b0, 2, 1};
        vecs[10] = '{1'b0, 3'd2, 32'h10, 32'h0,    5'd13, 32'h88123455, 1'b0, 2, 0};
`else
        vecs[6]  = '{1'b0, 3'd2, 32'h0E, 32'h0,    5'd9,  32'h0,        1'b1, 2, 0};
        vecs[9]  = '{1'b1, 3'd1, 32'h11, 32'h1234, 5'd12, 32'h0,        1'b1, 2, 0};
        vecs[10] = '{1'b0, 3'd2, 32'h10, 32'h0,    5'd13, 32'h88776655, 1'b0, 2, 0};
`endif
        vecs[7]  = '{1'b0, 3'd3, 32'h0C, 32'h0,    5'd10, 32'h0,        1'b0, 2, 0};
        vecs[8]  = '{1'b1, 3'd3, 32'h10, 32'hFFFF, 5'd11, 32'h0,        1'b0, 2, 0};
        vecs[11] = '{1'b0, 3'd5, 32'h0E, 32'h0,    5'd14, 32'h00004433, 1'b0, 2, 0};
        vecs[12] = '{1'b1, 3'd7, 32'h04, 32'hFFFF, 5'd15, 32'h0,        1'b0, 2, 0};

        for (int i = 0; i < 13; i++) begin
            modelAccess(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, md, mm, ml, mw);
            runChecked($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                       vecs[i].rd, 0, vecs[i].expData, vecs[i].expMis, vecs[i].expLat, vecs[i].expWrites, sw);
            if (i == 0) begin
                checkOutput("sbMemAddr", {24'b0, wrAddrLog[sw % 64]}, 32'd1);
                checkOutput("sbMemBe", {28'b0, wrBeLog[sw % 64]}, 32'b0010);
                checkOutput("sbMemWdata", wrDataLog[sw % 64], 32'h0000AB00);
            end
        end

        // Word store straddling the top of memory.
        modelAccess(1'b1, 3'd2, 32'(BYTES - 2), 32'hDDCCBBAA, md, mm, ml, mw);
        runChecked("swWrap", 1'b1, 3'd2, 32'(BYTES - 2), 32'hDDCCBBAA, 5'd16, 0, md, mm, ml, mw, sw);
`ifdef LSU_MISALIGNED_SPLIT_EN
        checkOutput("swWrapAddr0", {24'b0, wrAddrLog[sw % 64]}, SIZE - 1);
        checkOutput("swWrapBe0", {28'b0, wrBeLog[sw % 64]}, 32'b1100);
        checkOutput("swWrapData0", wrDataLog[sw % 64], 32'hBBAA0000);
        checkOutput("swWrapAddr1", {24'b0, wrAddrLog[(sw + 1) % 64]}, 32'd0);
        checkOutput("swWrapBe1", {28'b0, wrBeLog[(sw + 1) % 64]}, 32'b0011);
        checkOutput("swWrapData1", wrDataLog[(sw + 1) % 64], 32'h0000DDCC);
`endif
        modelAccess(1'b0, 3'd2, 32'(BYTES - 2), 32'h0, md, mm, ml, mw);
        runChecked("lwWrap", 1'b0, 3'd2, 32'(BYTES - 2), 32'h0, 5'd17, 0, md, mm, ml, mw, sw);

        modelAccess(1'b0, 3'd2, 32'h0C, 32'h0, md, mm, ml, mw);
        runChecked("backpressure", 1'b0, 3'd2, 32'h0C, 32'h0, 5'd18, 5, md, mm, ml, mw, sw);

        // Reset pulsed while a store sits in ACC0.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        req_rd = 5'd19; rsp_ready = 1'b0;
        sw = wrCount;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("acc0WriteStrobe", {31'b0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midResetRspValid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("midResetMemWe", {31'b0, mem_we}, 32'd0);
        checkOutput("midResetMemBe", {28'b0, mem_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midResetReady", {31'b0, req_ready}, 32'd1);
        checkOutput("midResetNoWrite", wrCount - sw, 32'd0);

        for (int n = 0; n < 300; n++) begin
            we    = 1'($urandom);
            f3    = 3'($urandom);
            addr  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom;
            wdata = $urandom;
            rd    = 5'($urandom);
            modelAccess(we, f3, addr, wdata, md, mm, ml, mw);
            runChecked($sformatf("rand%0d", n), we, f3, addr, wdata, rd, $urandom_range(0, 2),
                       md, mm, ml, mw, sw);
        end

        bad = 0;
        for (int w = 0; w < SIZE; w++)
            if (mem[w] !== {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]}) bad++;
        checkOutput("memImage", bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
